// File: rtl/ddc_mux_pkg.sv
// ---------------------------------------------------------------------------
// ddc_mux_pkg
// Shared definitions for the DDC channel multiplexers (serial-to-parallel on
// the receive side, parallel-to-serial on the transmit side).
//   CHIDX_I / CHIDX_Q : channel index tags carried with I and Q words
//   mux_state_e       : word-sequencing FSM states
//   width_convert()   : signed width conversion (sign-extend or keep MSBs)
// ---------------------------------------------------------------------------
package ddc_mux_pkg;

  localparam logic [3:0] CHIDX_I = 4'd0;
  localparam logic [3:0] CHIDX_Q = 4'd1;

  // Working width for width_convert(); both sample widths must fit inside it.
  localparam int CONV_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    SEND_I,
    GAP_I,
    SEND_Q,
    GAP_Q
  } mux_state_e;

  // din carries an in_w-bit sample already sign-extended to CONV_W bits. The
  // caller truncates the result to out_w bits. Narrowing drops LSBs with an
  // arithmetic shift (no rounding); widening or equal width needs no shift
  // because din is already sign-extended.
  function automatic logic signed [CONV_W-1:0] width_convert(
    input logic signed [CONV_W-1:0] din,
    input int                       in_w,
    input int                       out_w
  );
    if (out_w < in_w) return din >>> (in_w - out_w);
    else              return din;
  endfunction

endpackage

// File: rtl/mux_ps_pair_fifo.sv
// ---------------------------------------------------------------------------
// mux_ps_pair_fifo
// Single-clock synchronous FIFO used to buffer {I, Q} sample pairs.
// Pointers carry one extra bit so full and empty are distinguishable.
// The parent must only assert push when !full and pop when !empty; the
// read data is the current head entry (show-ahead).
//   CLK, nRST : clock, asynchronous active-low reset (pointers only)
//   push      : write wr_data at the tail
//   pop       : discard the head entry
//   wr_data   : entry to write
//   rd_data   : head entry
//   full      : DEPTH entries held
//   empty     : no entries held
//   level     : entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module mux_ps_pair_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // NOTE: the storage array is deliberately not reset; only the pointers
  // define which entries are valid, and a reset port on a RAM array blocks
  // inference of block/distributed memory.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // NOTE: all sequential state is updated with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/module_mux_ps.sv
// ---------------------------------------------------------------------------
// module_mux_ps
// Parallel-to-serial channel multiplexer: buffers I/Q pairs in a small FIFO
// and emits each pair as two tagged serial words (I then Q). Every word is a
// one-cycle valid pulse followed by VALID_GAP idle cycles.
//   CLK, nRST      : clock, asynchronous active-low reset
//   Data_In_I/Q    : signed input samples, captured on Data_In_Valid
//   Data_In_Valid  : single-cycle input strobe
//   Data_In_Ready  : FIFO not full (advisory)
//   Data_Out       : signed serial word (width-converted)
//   Data_Out_Valid : one-cycle pulse per word
//   Data_Out_ChIdx : I_CHIDX or Q_CHIDX tag for the current word
//   Overflow       : sticky, a pair was dropped on a full FIFO
//   Fifo_Level     : pairs currently buffered
// ---------------------------------------------------------------------------
module module_mux_ps
  import ddc_mux_pkg::*;
#(
  parameter int         INPUT_WIDTH  = 24,
  parameter int         OUTPUT_WIDTH = 24,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         VALID_GAP    = 1,
  parameter logic [3:0] I_CHIDX      = CHIDX_I,
  parameter logic [3:0] Q_CHIDX      = CHIDX_Q
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic signed [INPUT_WIDTH-1:0]    Data_In_I,
  input  logic signed [INPUT_WIDTH-1:0]    Data_In_Q,
  input  logic                             Data_In_Valid,
  output logic                             Data_In_Ready,
  output logic signed [OUTPUT_WIDTH-1:0]   Data_Out,
  output logic                             Data_Out_Valid,
  output logic [3:0]                       Data_Out_ChIdx,
  output logic                             Overflow,
  output logic [$clog2(FIFO_DEPTH):0]      Fifo_Level
);

  logic                           fifo_full;
  logic                           fifo_empty;
  logic                           push;
  logic                           pop;
  logic [2*INPUT_WIDTH-1:0]       fifo_rd;
  logic signed [INPUT_WIDTH-1:0]  fifo_i;
  logic signed [INPUT_WIDTH-1:0]  fifo_q;
  logic signed [OUTPUT_WIDTH-1:0] conv_i;
  logic signed [OUTPUT_WIDTH-1:0] conv_q;
  logic signed [OUTPUT_WIDTH-1:0] hold_i;
  logic signed [OUTPUT_WIDTH-1:0] hold_q;
  mux_state_e                     state;
  logic [3:0]                     gap_cnt;
  logic                           gap_done;

  // Full is the pre-edge value, so a pair arriving on a full FIFO is dropped
  // even if the FSM pops on the same edge.
  assign push     = Data_In_Valid && !fifo_full;
  assign gap_done = (gap_cnt == 4'(VALID_GAP - 1));

  // A pair is taken either from IDLE or directly at the end of GAP_Q, which
  // removes the IDLE cycle under sustained input.
  assign pop = !fifo_empty &&
               ((state == IDLE) || ((state == GAP_Q) && gap_done));

  mux_ps_pair_fifo #(
    .WIDTH (2*INPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .nRST    (nRST),
    .push    (push),
    .pop     (pop),
    .wr_data ({Data_In_I, Data_In_Q}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (Fifo_Level)
  );

  assign fifo_i = fifo_rd[2*INPUT_WIDTH-1:INPUT_WIDTH];
  assign fifo_q = fifo_rd[INPUT_WIDTH-1:0];

  assign conv_i = OUTPUT_WIDTH'(width_convert(CONV_W'(fifo_i), INPUT_WIDTH, OUTPUT_WIDTH));
  assign conv_q = OUTPUT_WIDTH'(width_convert(CONV_W'(fifo_q), INPUT_WIDTH, OUTPUT_WIDTH));

  assign Data_In_Ready = !fifo_full;

  // Outputs are registered from the state: the word driven while in SEND_x
  // appears on the output the cycle after, so Data_Out_Valid is high for
  // exactly one cycle per word and low for VALID_GAP cycles after it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state          <= IDLE;
      gap_cnt        <= '0;
      hold_i         <= '0;
      hold_q         <= '0;
      Data_Out       <= '0;
      Data_Out_Valid <= 1'b0;
      Data_Out_ChIdx <= I_CHIDX;
      Overflow       <= 1'b0;
    end else begin
      Data_Out_Valid <= 1'b0;

      if (Data_In_Valid && fifo_full) Overflow <= 1'b1;

      // Both words are captured at pop time; the FIFO head moves on after.
      if (pop) begin
        hold_i <= conv_i;
        hold_q <= conv_q;
      end

      case (state)
        IDLE: begin
          if (pop) state <= SEND_I;
        end
        SEND_I: begin
          Data_Out       <= hold_i;
          Data_Out_ChIdx <= I_CHIDX;
          Data_Out_Valid <= 1'b1;
          gap_cnt        <= '0;
          state          <= GAP_I;
        end
        GAP_I: begin
          if (gap_done) state <= SEND_Q;
          else          gap_cnt <= gap_cnt + 1'b1;
        end
        SEND_Q: begin
          Data_Out       <= hold_q;
          Data_Out_ChIdx <= Q_CHIDX;
          Data_Out_Valid <= 1'b1;
          gap_cnt        <= '0;
          state          <= GAP_Q;
        end
        GAP_Q: begin
          if (gap_done) state <= pop ? SEND_I : IDLE;
          else          gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
